spi_lcd_rx: RTL and testbench



---
 rtl/spi_lcd_rx_pkg.sv | 29 ++
 rtl/spi_lcd_rx_fifo.sv | 62 ++++++
 rtl/spi_lcd_rx.sv | 172 +++++++++++++++++
 tb/tb_spi_lcd_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_lcd_rx_pkg.sv
// Shared types and constants for the SPI LCD receiver: FSM encoding, word and
// FIFO entry widths, and the bus idle levels the synchronizers reset to.
package spi_lcd_rx_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int WORD8_W  = 8;
  localparam int WORD16_W = 16;
  localparam int ENTRY_W  = WORD16_W + 1;

  localparam logic IDLE_CLK  = 1'b1;
  localparam logic IDLE_CSS  = 1'b1;
  localparam logic IDLE_MOSI = 1'b1;
  localparam logic IDLE_GPO  = 1'b0;

  typedef struct packed {
    logic                dc;
    logic [WORD16_W-1:0] data;
  } entry_t;

  // Index of the bit whose rising edge completes a word.
  function automatic logic [3:0] last_bit(input logic mode16);
    return mode16 ? 4'(WORD16_W - 1) : 4'(WORD8_W - 1);
  endfunction

endpackage

// File: rtl/spi_lcd_rx_fifo.sv
// Single-clock FIFO of received words. A push while full is dropped unless a
// pop frees the head slot in the same cycle; flush empties it synchronously.
module spi_lcd_rx_fifo
  import spi_lcd_rx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   flush_i,
  input  logic   push_i,
  input  entry_t wdata_i,
  input  logic   pop_i,
  output entry_t rdata_o,
  output logic   full_o,
  output logic   empty_o,
  output logic   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
  logic               wr_en, rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_en   = pop_i & ~empty_o;
  // When full, the slot being written is the one popped this cycle.
  assign wr_en   = push_i & (~full_o | rd_en);
  assign drop_o  = push_i & ~wr_en;

  assign rdata_o = empty_o ? '0 : entry_t'(mem_q[rd_q[AW-1:0]]);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (wr_en) wr_d = wr_q + PTR_ONE;
      if (rd_en) rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spi_lcd_rx.sv
// SPI (mode 3, MSB first) receiver for an LCD host bus, word FIFO and
// optional statistics counters enabled by SPI_LCD_RX_STATS_EN.
module spi_lcd_rx
  import spi_lcd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_en,
  input  logic        i_mode,
  input  logic        SPI_CLK,
  input  logic        SPI_CSS,
  input  logic        SPI_MOSI,
  input  logic        SPI_GPO,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_data,
  output logic        o_dc,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_frame_err,
  output logic [15:0] o_word_cnt,
  output logic [7:0]  o_err_cnt
);

  localparam logic [3:0] BUS_IDLE = {IDLE_CLK, IDLE_CSS, IDLE_MOSI, IDLE_GPO};

  // Bus synchronizer: bit order {clk, css, mosi, gpo}.
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  bus_s, bus_prev_q;
  logic sclk_rise, css_fall, css_rise, mosi_s, gpo_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= {SYNC_STAGES{BUS_IDLE}};
      bus_prev_q <= BUS_IDLE;
    end else begin
      sync_q[0] <= {SPI_CLK, SPI_CSS, SPI_MOSI, SPI_GPO};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      bus_prev_q <= bus_s;
    end
  end

  assign bus_s     = sync_q[SYNC_STAGES-1];
  assign sclk_rise = bus_s[3] & ~bus_prev_q[3];
  assign css_fall  = ~bus_s[2] & bus_prev_q[2];
  assign css_rise  = bus_s[2] & ~bus_prev_q[2];
  assign mosi_s    = bus_s[1];
  assign gpo_s     = bus_s[0];

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        mode_q, mode_d;
  logic [15:0] sr_q, sr_d;
  logic        push, frame_err;
  entry_t      push_entry;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    mode_d     = mode_q;
    sr_d       = sr_q;
    push       = 1'b0;
    push_entry = '0;
    frame_err  = 1'b0;
    if (!i_en) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (css_fall) begin
            state_d   = ST_ACTIVE;
            bit_cnt_d = '0;
            mode_d    = i_mode;
          end
        end
        ST_ACTIVE: begin
          if (css_rise) begin
            state_d   = ST_IDLE;
            frame_err = (bit_cnt_q != '0);
            bit_cnt_d = '0;
          end else if (sclk_rise) begin
            sr_d = {sr_q[14:0], mosi_s};
            if (bit_cnt_q == last_bit(mode_q)) begin
              push            = 1'b1;
              bit_cnt_d       = '0;
              push_entry.dc   = gpo_s;
              push_entry.data = mode_q ? sr_d : {sr_d[7:0], 8'h00};
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      mode_q    <= 1'b0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      mode_q    <= mode_d;
      sr_q      <= sr_d;
    end
  end

  entry_t head;
  logic   empty, full, drop;
  logic   ovf_q, ferr_q;

  spi_lcd_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush_i (~i_en),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (o_valid & i_ready),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .drop_o  (drop)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= drop;
      ferr_q <= frame_err;
    end
  end

  assign o_valid     = ~empty;
  assign o_data      = head.data;
  assign o_dc        = head.dc;
  assign o_busy      = (state_q == ST_ACTIVE);
  assign o_overflow  = ovf_q;
  assign o_frame_err = ferr_q;

`ifdef SPI_LCD_RX_STATS_EN
  logic [15:0] word_cnt_q;
  logic [7:0]  err_cnt_q;

  // Saturating counters; they simply stop counting while disabled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (push && !drop && word_cnt_q != '1) word_cnt_q <= word_cnt_q + 16'd1;
      if ((drop || frame_err) && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign o_word_cnt = word_cnt_q;
  assign o_err_cnt  = err_cnt_q;
`else
  assign o_word_cnt = '0;
  assign o_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx: byte/word reception, frame error, overflow,
// reset and disable behaviour, with counter expectations per build option.
module tb_spi_lcd_rx;

`ifdef SPI_LCD_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, i_en, i_mode, i_ready;
  logic        SPI_CLK, SPI_CSS, SPI_MOSI, SPI_GPO;
  logic        o_valid, o_dc, o_busy, o_overflow, o_frame_err;
  logic [15:0] o_data, o_word_cnt;
  logic [7:0]  o_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ovf_n   = 0;
  int ferr_n  = 0;
  logic [16:0] rxq[$];

  always #5 clk = ~clk;

  spi_lcd_rx #(.FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .i_en(i_en), .i_mode(i_mode),
    .SPI_CLK(SPI_CLK), .SPI_CSS(SPI_CSS), .SPI_MOSI(SPI_MOSI), .SPI_GPO(SPI_GPO),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_dc(o_dc),
    .o_busy(o_busy), .o_overflow(o_overflow), .o_frame_err(o_frame_err),
    .o_word_cnt(o_word_cnt), .o_err_cnt(o_err_cnt)
  );

  // Inputs change at posedge+2, so negedge sees a stable handshake.
  always @(negedge clk) begin
    if (resetn) begin
      if (o_valid && i_ready) rxq.push_back({o_dc, o_data});
      if (o_overflow) ovf_n++;
      if (o_frame_err) ferr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic spi_bits(input logic [15:0] w, input int n, input logic gpo);
    for (int i = n - 1; i >= 0; i--) begin
      SPI_CLK = 1'b0; SPI_MOSI = w[i]; SPI_GPO = gpo;
      tick(4);
      SPI_CLK = 1'b1;
      tick(4);
    end
  endtask

  task automatic css_low();
    SPI_CSS = 1'b0;
    tick(4);
  endtask

  task automatic css_high();
    SPI_CSS = 1'b1;
    SPI_MOSI = 1'b1;
    SPI_GPO = 1'b0;
    tick(6);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(2);
  endtask

  initial begin
    int bad;
    resetn = 1'b0; i_en = 1'b0; i_mode = 1'b0; i_ready = 1'b0;
    SPI_CLK = 1'b1; SPI_CSS = 1'b1; SPI_MOSI = 1'b1; SPI_GPO = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_ferr", o_frame_err, 0);
    chk("rst_data", {o_dc, o_data}, 0);
    chk("rst_cnts", {o_word_cnt, o_err_cnt}, 0);
    resetn = 1'b1; i_en = 1'b1;
    tick(4);
    @(negedge clk);
    chk("idle_no_edge", {o_busy, o_valid, o_frame_err}, 0);

    // Mode 0: 0x2A (D/C=0) then 0x00 (D/C=1), consumer stalled.
    tick(1);
    css_low();
    @(negedge clk);
    chk("busy_active", o_busy, 1);
    tick(1);
    spi_bits(16'h002A, 8, 1'b0);
    @(negedge clk);
    chk("b0_valid", o_valid, 1);
    chk("b0_head", {o_dc, o_data}, 17'h02A00);
    tick(1);
    spi_bits(16'h0000, 8, 1'b1);
    @(negedge clk);
    chk("head_stable", {o_dc, o_data}, 17'h02A00);
    tick(1);
    css_high();
    @(negedge clk);
    chk("busy_idle", o_busy, 0);
    chk("b_no_ferr", ferr_n, 0);
    tick(1);
    i_ready = 1'b1;
    tick(3);
    i_ready = 1'b0;
    chk("b_pop_cnt", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk("b_pop0", rxq[0], 17'h02A00);
      chk("b_pop1", rxq[1], 17'h10000);
    end
    @(negedge clk);
    chk("b_empty", o_valid, 0);
    tick(1);

    // Mode 1: 100 back-to-back 0xF800 words, consumer always ready.
    do_reset();
    rxq.delete();
    i_mode = 1'b1; i_ready = 1'b1;
    css_low();
    i_mode = 1'b0;
    for (int k = 0; k < 100; k++) spi_bits(16'hF800, 16, 1'b1);
    css_high();
    chk("w_pop_cnt", rxq.size(), 100);
    bad = 0;
    foreach (rxq[k]) if (rxq[k] !== 17'h1F800) bad++;
    chk("w_pop_data", bad, 0);
    chk("w_word_cnt", o_word_cnt, STATS ? 100 : 0);
    chk("w_err_cnt", o_err_cnt, 0);

    // Frame error after 5 bits, then a clean 0x11.
    rxq.delete();
    css_low();
    spi_bits(16'h0015, 5, 1'b0);
    css_high();
    chk("fe_pulses", ferr_n, 1);
    chk("fe_no_push", rxq.size(), 0);
    chk("fe_err_cnt", o_err_cnt, STATS ? 1 : 0);
    css_low();
    spi_bits(16'h0011, 8, 1'b0);
    css_high();
    chk("fe_next_cnt", rxq.size(), 1);
    if (rxq.size() == 1) chk("fe_next_data", rxq[0], 17'h01100);
    chk("fe_pulses_after", ferr_n, 1);

    // Overflow: 17 bytes into a 16-deep FIFO with the consumer stalled.
    rxq.delete();
    i_ready = 1'b0;
    css_low();
    for (int k = 0; k <= 16; k++) spi_bits(16'(k), 8, 1'b0);
    css_high();
    chk("ov_pulses", ovf_n, 1);
    chk("ov_err_cnt", o_err_cnt, STATS ? 2 : 0);
    chk("ov_word_cnt", o_word_cnt, STATS ? 117 : 0);
    i_ready = 1'b1;
    tick(24);
    i_ready = 1'b0;
    chk("ov_pop_cnt", rxq.size(), 16);
    bad = 0;
    foreach (rxq[k]) if (rxq[k] !== {1'b0, 8'(k), 8'h00}) bad++;
    chk("ov_pop_data", bad, 0);

    // Reset mid-word, then disable with 3 words queued.
    css_low();
    spi_bits(16'h0005, 3, 1'b0);
    resetn = 1'b0;
    SPI_CSS = 1'b1; SPI_CLK = 1'b1;
    tick(2);
    @(negedge clk);
    chk("mr_outs", {o_valid, o_busy, o_overflow, o_frame_err, o_dc, o_data}, 0);
    chk("mr_cnts", {o_word_cnt, o_err_cnt}, 0);
    tick(1);
    resetn = 1'b1;
    tick(4);
    @(negedge clk);
    chk("mr_idle", {o_valid, o_busy}, 0);
    tick(1);
    css_low();
    for (int k = 0; k < 3; k++) spi_bits(16'h00A0 + 16'(k), 8, 1'b1);
    css_high();
    @(negedge clk);
    chk("dis_valid_before", o_valid, 1);
    chk("dis_head", {o_dc, o_data}, 17'h1A000);
    @(posedge clk);
    #2;
    i_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("dis_valid_after", o_valid, 0);
    chk("dis_word_cnt", o_word_cnt, STATS ? 3 : 0);
    chk("dis_busy", o_busy, 0);
    tick(2);
    i_en = 1'b1;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
